bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-core memory bus arbiter sharing the single RAM port between the instruction and data requests of core 0 and core 1. It sits between the cores' cache request signals and the RAM, in front of the coherency path. It grants one requester at a time, holds data grants for a full cache-block burst and round-robins between cores. An age counter guarantees instruction fetches are not starved by back-to-back data traffic.

## Interface
Parameters:
- BLOCK_WORDS, 2: RAM words per data grant (cache block burst); ≥1.
- MAX_WAIT, 8: cycles an instruction request may wait before it outranks data requests; ≥1.

Ports (index [c] = core 0/1; word_t, ramstate_t from cpu_types_pkg):
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- iREN  in  [1:0]  instruction read request per core.
- iaddr  in  word_t[1:0]  instruction address.
- iwait  out  [1:0]  instruction wait.
- iload  out  word_t[1:0]  instruction data.
- dREN, dWEN  in  [1:0]  data read / write request per core.
- daddr, dstore  in  word_t[1:0]  data address / write data.
- dwait  out  [1:0]  data wait.
- dload  out  word_t[1:0]  data read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
- ramload  in  word_t  RAM read data.
- ramaddr, ramstore  out  word_t  RAM address / write data.
- ramREN, ramWEN  out  1  RAM read / write enable.

## Operation
- States: IDLE, GNT_I, GNT_D. Registered: state, owner core `own`, word count `wcnt`, round-robin pointers `irr`, `drr`, age counters `iage[c]`.
- IDLE: pick a grant, move to GNT_I/GNT_D next cycle. Priority:
  1. Aged fetch: iREN[c] and iage[c]==MAX_WAIT; both aged → irr.
  2. Data: dREN|dWEN; both cores → drr.
  3. Fetch: iREN; both → irr.
  4. Otherwise stay IDLE.
- GNT_I: ramaddr=iaddr[own], ramREN=iREN[own], iload[own]=ramload. Release to IDLE after the ACCESS cycle, or immediately (next cycle) if iREN[own] drops. On release, irr=!own.
- GNT_D: ramaddr=daddr[own]. If dWEN[own]: ramWEN=1, ramstore=dstore[own]. Else ramREN=dREN[own], dload[own]=ramload. dWEN wins if both asserted. Each ACCESS cycle increments wcnt. Release on the ACCESS cycle with wcnt==BLOCK_WORDS-1, or when dREN|dWEN of own drops. On release, drr=!own, wcnt=0.
- Waits: iwait[c]=iREN[c] && !(GNT_I && own==c && ramstate==ACCESS). dwait[c] is the same form for data. FREE, BUSY and ERROR all keep wait high.
- iage[c]: +1 per cycle while iREN[c] and c not granted; saturate at MAX_WAIT. Clear when iREN[c] is low or on GNT_I to c.
- Ungranted outputs: iload/dload are 0 and RAM controls are 0 in IDLE.

## Timing
- Reset (RST high, async): state=IDLE, own=0, wcnt=0, irr=drr=0, iage=0.
- Outputs during reset: ram*=0, iload=dload=0. iwait/dwait follow their request (high if requested).
- Minimum latency: request sampled in IDLE at cycle n, grant at n+1. With ramstate==ACCESS at n+1, wait is low at n+1.
- One IDLE cycle always separates grants; there is no back-to-back re-grant.
- Mid-burst: a data grant is not preempted, even by an aged fetch. The age counter keeps counting.
- Reset mid-burst: RAM enables drop in the same cycle (combinational from state).
- Simultaneous requests: both cores fetch with irr=0 → core 0 first, then core 1.

## Structure
- cpu_types_pkg: add `arbstate_t` enum {IDLE, GNT_I, GNT_D}. Reuse word_t and ramstate_t.
- Sub-module `rr_pick2`: combinational 2-way round-robin picker (req[1:0], ptr → valid, sel). Instantiated for aged-fetch, data and fetch selection.
- Counter widths: wcnt uses $clog2(BLOCK_WORDS) bits (min 1); iage uses $clog2(MAX_WAIT+1) bits.

## Test plan
- Single fetch: core0 iREN, iaddr=0x40, ramstate ACCESS every cycle → grant cycle 1, ramaddr=0x40, iwait[0] low at cycle 1, iload[0]=ramload; back to IDLE at cycle 2.
- Data burst: core1 dWEN with daddr 0x100 then 0x104, BLOCK_WORDS=2, RAM BUSY 2 cycles per word → two ramWEN words; core0 iREN held off until the burst releases; drr becomes 0.
- Round-robin: both cores dREN continuously → grants alternate core0, core1, core0; each holds 2 ACCESS cycles.
- Starvation: core0 dREN held permanently, core1 iREN → core1 fetch granted once iage reaches 8, no later than the first IDLE after that point.
- Request drop: core0 dREN drops after 1 word of a 2-word grant → ramREN low next cycle, return to IDLE, wcnt=0.
- Reset mid-burst: RST pulsed during GNT_D → ramWEN/ramREN 0 immediately; state IDLE, counters 0 after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types and arbiter state encoding
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arbstate_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       sel
);

    // ptr names the favoured core when both request; otherwise take the lone requester
    always_comb begin
        valid = |req;
        sel   = (&req) ? ptr : req[1];
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-core instruction/data arbiter for a single RAM port
module bus_arbiter
    import cpu_types_pkg::*;
#(
    parameter int BLOCK_WORDS = 2,
    parameter int MAX_WAIT    = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic      [1:0] iREN,
    input  word_t     [1:0] iaddr,
    output logic      [1:0] iwait,
    output word_t     [1:0] iload,
    input  logic      [1:0] dREN,
    input  logic      [1:0] dWEN,
    input  word_t     [1:0] daddr,
    input  word_t     [1:0] dstore,
    output logic      [1:0] dwait,
    output word_t     [1:0] dload,
    input  ramstate_t       ramstate,
    input  word_t           ramload,
    output word_t           ramaddr,
    output word_t           ramstore,
    output logic            ramREN,
    output logic            ramWEN
);

    localparam int WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int AW  = $clog2(MAX_WAIT + 1);

    arbstate_t            state;
    logic                 own;
    logic [WCW-1:0]       wcnt;
    logic                 irr;
    logic                 drr;
    logic [1:0][AW-1:0]   iage;

    logic [1:0] aged_req;
    logic [1:0] dreq;
    logic       aged_v, aged_sel;
    logic       d_v, d_sel;
    logic       f_v, f_sel;
    logic       access;
    logic       last_word;

    // Request classification feeding the three pickers
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            aged_req[c] = iREN[c] && (iage[c] == AW'(MAX_WAIT));
        end
        dreq      = dREN | dWEN;
        access    = (ramstate == ACCESS);
        last_word = (wcnt == WCW'(BLOCK_WORDS - 1));
    end

    rr_pick2 u_pick_aged (.req(aged_req), .ptr(irr), .valid(aged_v), .sel(aged_sel));
    rr_pick2 u_pick_data (.req(dreq),     .ptr(drr), .valid(d_v),    .sel(d_sel));
    rr_pick2 u_pick_ftch (.req(iREN),     .ptr(irr), .valid(f_v),    .sel(f_sel));

    // Grant FSM: every grant returns through IDLE, bursts run to completion
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            own   <= 1'b0;
            wcnt  <= '0;
            irr   <= 1'b0;
            drr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aged_v) begin
                        state <= GNT_I;
                        own   <= aged_sel;
                    end else if (d_v) begin
                        state <= GNT_D;
                        own   <= d_sel;
                    end else if (f_v) begin
                        state <= GNT_I;
                        own   <= f_sel;
                    end
                end
                GNT_I: begin
                    if (access || !iREN[own]) begin
                        state <= IDLE;
                        irr   <= !own;
                    end
                end
                GNT_D: begin
                    if (!dreq[own] || (access && last_word)) begin
                        state <= IDLE;
                        drr   <= !own;
                        wcnt  <= '0;
                    end else if (access) begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fetch age: counts while a core waits for a fetch, saturating at MAX_WAIT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            iage <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (!iREN[c] || (state == GNT_I && own == 1'(c))) begin
                    iage[c] <= '0;
                end else if (iage[c] != AW'(MAX_WAIT)) begin
                    iage[c] <= iage[c] + AW'(1);
                end
            end
        end
    end

    // RAM port steering and wait generation, decoded from the current grant
    always_comb begin
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        iload    = '0;
        dload    = '0;
        for (int c = 0; c < 2; c++) begin
            iwait[c] = iREN[c] && !(state == GNT_I && own == 1'(c) && access);
            dwait[c] = dreq[c] && !(state == GNT_D && own == 1'(c) && access);
        end
        case (state)
            GNT_I: begin
                ramaddr    = iaddr[own];
                ramREN     = iREN[own];
                iload[own] = ramload;
            end
            GNT_D: begin
                ramaddr = daddr[own];
                if (dWEN[own]) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore[own];
                end else begin
                    ramREN     = dREN[own];
                    dload[own] = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed check of bus_arbiter against a transaction model
module tb_bus_arbiter;
    import cpu_types_pkg::*;

    localparam int BW   = 2;
    localparam int MAXW = 8;

    logic            CLK = 1'b0;
    logic            RST;
    logic      [1:0] iREN, dREN, dWEN;
    word_t     [1:0] iaddr, daddr, dstore;
    logic      [1:0] iwait, dwait;
    word_t     [1:0] iload, dload;
    ramstate_t       ramstate;
    word_t           ramload, ramaddr, ramstore;
    logic            ramREN, ramWEN;

    int vectors    = 0;
    int miscompares = 0;

    // model: current grant (0 none, 1 fetch, 2 data), its core, words moved, preferences, ages
    int m_kind, m_core, m_words, m_pi, m_pd;
    int m_age [2];

    always #5 CLK = ~CLK;

    bus_arbiter #(.BLOCK_WORDS(BW), .MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramstate(ramstate), .ramload(ramload),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramREN(ramREN), .ramWEN(ramWEN)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_kind = 0; m_core = 0; m_words = 0; m_pi = 0; m_pd = 0;
        m_age[0] = 0; m_age[1] = 0;
    endtask

    task automatic check_outputs();
        logic [1:0]      e_iw, e_dw;
        logic [1:0][31:0] e_il, e_dl;
        logic [31:0]     e_ra, e_rs;
        logic            e_ren, e_wen;
        bit              acc;
        acc = (ramstate == ACCESS);
        e_il = '0; e_dl = '0; e_ra = '0; e_rs = '0; e_ren = 0; e_wen = 0;
        for (int c = 0; c < 2; c++) begin
            e_iw[c] = iREN[c] && !(m_kind == 1 && m_core == c && acc);
            e_dw[c] = (dREN[c] || dWEN[c]) && !(m_kind == 2 && m_core == c && acc);
        end
        if (m_kind == 1) begin
            e_ra = iaddr[m_core];
            e_ren = iREN[m_core];
            e_il[m_core] = ramload;
        end else if (m_kind == 2) begin
            e_ra = daddr[m_core];
            if (dWEN[m_core]) begin
                e_wen = 1; e_rs = dstore[m_core];
            end else begin
                e_ren = dREN[m_core]; e_dl[m_core] = ramload;
            end
        end
        chk("iwait", 64'(iwait), 64'(e_iw));
        chk("dwait", 64'(dwait), 64'(e_dw));
        chk("iload", iload, e_il);
        chk("dload", dload, e_dl);
        chk("ramaddr", 64'(ramaddr), 64'(e_ra));
        chk("ramstore", 64'(ramstore), 64'(e_rs));
        chk("ram_en", 64'({ramREN, ramWEN}), 64'({e_ren, e_wen}));
    endtask

    // pick among requesters: both -> preferred core, else the single one, -1 none
    function automatic int pick(input bit r0, input bit r1, input int pref);
        if (r0 && r1) return pref;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_advance();
        int old_age [2];
        int p;
        bit acc;
        acc = (ramstate == ACCESS);
        old_age = m_age;
        for (int c = 0; c < 2; c++) begin
            if (!iREN[c] || (m_kind == 1 && m_core == c)) m_age[c] = 0;
            else if (m_age[c] < MAXW) m_age[c] = m_age[c] + 1;
        end
        if (m_kind == 0) begin
            p = pick(iREN[0] && old_age[0] == MAXW, iREN[1] && old_age[1] == MAXW, m_pi);
            if (p >= 0) begin m_kind = 1; m_core = p; end
            else begin
                p = pick(dREN[0] || dWEN[0], dREN[1] || dWEN[1], m_pd);
                if (p >= 0) begin m_kind = 2; m_core = p; end
                else begin
                    p = pick(iREN[0], iREN[1], m_pi);
                    if (p >= 0) begin m_kind = 1; m_core = p; end
                end
            end
        end else if (m_kind == 1) begin
            if (acc || !iREN[m_core]) begin m_kind = 0; m_pi = 1 - m_core; end
        end else begin
            if (!(dREN[m_core] || dWEN[m_core])) begin
                m_kind = 0; m_pd = 1 - m_core; m_words = 0;
            end else if (acc) begin
                m_words++;
                if (m_words == BW) begin m_kind = 0; m_pd = 1 - m_core; m_words = 0; end
            end
        end
    endtask

    task automatic cycle();
        #1;
        check_outputs();
        model_advance();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = '0;
    endtask

    initial begin
        bit found;
        RST = 1;
        clear_inputs();
        model_reset();
        @(negedge CLK);
        // reset state: waits follow requests, RAM idle
        iREN = 2'b10; dREN = 2'b01;
        #1;
        check_outputs();
        @(posedge CLK);
        @(negedge CLK);
        RST = 0;
        clear_inputs();

        // single fetch from core 0
        iREN = 2'b01; iaddr[0] = 32'h40; ramstate = ACCESS; ramload = 32'hCAFE0001;
        cycle();
        #1;
        chk("fetch_addr", 64'(ramaddr), 64'h40);
        chk("fetch_iwait0", 64'(iwait[0]), 64'd0);
        cycle();
        iREN = 0;
        cycle();

        // core 1 burst write with slow RAM, core 0 fetch waiting behind it
        dWEN = 2'b10; daddr[1] = 32'h100; dstore[1] = 32'h11; ramstate = BUSY;
        cycle();
        iREN = 2'b01;
        for (int i = 0; i < 12; i++) begin
            ramstate = (i % 3 == 2) ? ACCESS : BUSY;
            if (i >= 3) begin daddr[1] = 32'h104; dstore[1] = 32'h22; end
            cycle();
        end
        dWEN = 0; iREN = 0; ramstate = ACCESS;
        cycle(); cycle();

        // round-robin data reads, then a drop after one word
        dREN = 2'b11;
        daddr[0] = 32'h200; daddr[1] = 32'h300;
        for (int i = 0; i < 10; i++) cycle();
        dREN = 2'b00;
        cycle(); cycle();
        dREN = 2'b01;
        cycle(); cycle();
        dREN = 2'b00;
        cycle(); cycle();

        // starvation: core 0 data forever, core 1 fetch must get through
        dREN = 2'b01; iREN = 2'b10; iaddr[1] = 32'h80;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            #1;
            if (!iwait[1]) found = 1;
        end
        chk("starve_grant", 64'(found), 64'd1);
        dREN = 0; iREN = 0;
        cycle(); cycle();

        // reset asserted in the middle of a write burst
        dWEN = 2'b10; ramstate = BUSY; dstore[1] = 32'h5A5A;
        cycle(); cycle();
        #1;
        chk("pre_rst_wen", 64'(ramWEN), 64'd1);
        RST = 1;
        #1;
        chk("rst_wen", 64'(ramWEN), 64'd0);
        chk("rst_ren", 64'(ramREN), 64'd0);
        model_reset();
        check_outputs();
        @(posedge CLK);
        @(negedge CLK);
        RST = 0;
        dWEN = 0;
        cycle();

        // random traffic with sticky requests
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(3) == 0) iREN[c] = ~iREN[c];
                if ($urandom_range(5) == 0) dREN[c] = ~dREN[c];
                if ($urandom_range(7) == 0) dWEN[c] = ~dWEN[c];
                iaddr[c]  = $urandom;
                daddr[c]  = $urandom;
                dstore[c] = $urandom;
            end
            case ($urandom_range(7))
                0: ramstate = FREE;
                1, 2: ramstate = BUSY;
                3: ramstate = ERROR;
                default: ramstate = ACCESS;
            endcase
            ramload = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
